alu: RTL and testbench

- Parameterised two-operand signed ALU with registered outputs: add, subtract, bitwise AND, bitwise OR.
- Used as a datapath leaf; instantiated at several widths (8 and 16 bits) from a common opcode bus.
- Result and status flags are captured on the clock edge, one cycle after a valid input is presented.

---
 rtl/alu.sv | 61 ++++++
 tb/tb_alu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: two-operand signed ALU (add/sub/and/or) with one registered output stage
// and registered zero/negative/carry/overflow flags.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);
    localparam int M = WIDTH - 1;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q, overflow_d, overflow_q;
    logic             valid_q, zero_q, negative_q;
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        result_d   = opcode == 2'b00 ? sum[M:0] :
                     opcode == 2'b01 ? diff[M:0] :
                     opcode == 2'b10 ? (a & b) : (a | b);
        // the extra MSB of the widened difference is the unsigned borrow
        carry_d    = opcode == 2'b00 ? sum[WIDTH] :
                     opcode == 2'b01 ? diff[WIDTH] : 1'b0;
        overflow_d = opcode == 2'b00 ? (a[M] == b[M]) && (result_d[M] != a[M]) :
                     opcode == 2'b01 ? (a[M] != b[M]) && (result_d[M] != a[M]) : 1'b0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            valid_q    <= 1'b0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                zero_q     <= result_d == '0;
                negative_q <= result_d[M];
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
            end
        end
    end
    assign result    = result_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven checks of 8- and 16-bit alu instances plus hold,
// asynchronous reset and back-to-back sequences.
module tb_alu;
    logic        clk = 0, reset = 1;
    logic        iv8 = 0, iv16 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic [1:0]  op = 0;
    logic [7:0]  r8;
    logic [15:0] r16;
    logic        ov8, z8, n8, c8, v8, ov16, z16, n16, c16, v16;
    int          errors = 0, checks = 0;

    alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .a(a8), .b(b8), .opcode(op),
        .result(r8), .out_valid(ov8), .zero(z8), .negative(n8), .carry(c8), .overflow(v8)
    );
    alu #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .a(a16), .b(b16), .opcode(op),
        .result(r16), .out_valid(ov16), .zero(z16), .negative(n16), .carry(c16), .overflow(v16)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w16;
        logic [15:0] a, b;
        logic [1:0]  op;
        logic [15:0] r;
        logic        z, n, c, v;
        string       nm;
    } vec_t;

    function automatic vec_t mk(bit w, logic [15:0] av, logic [15:0] bv, logic [1:0] o,
                                logic [15:0] r, logic z, logic n, logic c, logic v, string nm);
        vec_t t;
        t.w16 = w; t.a = av; t.b = bv; t.op = o; t.r = r;
        t.z = z; t.n = n; t.c = c; t.v = v; t.nm = nm;
        return t;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(vec_t t);
        @(negedge clk);
        a8 = t.a[7:0]; b8 = t.b[7:0]; a16 = t.a; b16 = t.b; op = t.op;
        iv8 = !t.w16; iv16 = t.w16;
        @(posedge clk);
        #1;
        if (t.w16) begin
            chk({t.nm, ".result"}, r16, t.r);
            chk({t.nm, ".flags"}, {12'h0, ov16, z16, n16, c16, v16}, {12'h0, 1'b1, t.z, t.n, t.c, t.v});
        end else begin
            chk({t.nm, ".result"}, {8'h0, r8}, t.r);
            chk({t.nm, ".flags"}, {12'h0, ov8, z8, n8, c8, v8}, {12'h0, 1'b1, t.z, t.n, t.c, t.v});
        end
    endtask

    // independent 8-bit reference using integer arithmetic
    function automatic vec_t model8(int ua, int ub, logic [1:0] o);
        int sa, sb, full, s;
        logic [7:0] r;
        logic c, v;
        sa = ua > 127 ? ua - 256 : ua;
        sb = ub > 127 ? ub - 256 : ub;
        c = 0; v = 0;
        if (o == 2'b00) begin
            full = ua + ub; s = sa + sb; c = full > 255; v = s > 127 || s < -128;
        end else if (o == 2'b01) begin
            full = ua - ub; s = sa - sb; c = ua < ub; v = s > 127 || s < -128;
        end else if (o == 2'b10) full = ua & ub;
        else full = ua | ub;
        r = full[7:0];
        return mk(0, 16'(ua), 16'(ub), o, {8'h0, r}, r == 0, r[7], c, v, "b2b");
    endfunction

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk(0, 10, 20, 2'b00, 16'd30,   0, 0, 0, 0, "w8_add");
        vecs[1]  = mk(0, 10, 20, 2'b01, 16'h00F6, 0, 1, 1, 0, "w8_sub");
        vecs[2]  = mk(0, 10, 20, 2'b10, 16'd0,    1, 0, 0, 0, "w8_and");
        vecs[3]  = mk(0, 10, 20, 2'b11, 16'd30,   0, 0, 0, 0, "w8_or");
        vecs[4]  = mk(1, 230, 300, 2'b00, 16'd530, 0, 0, 0, 0, "w16_add");
        vecs[5]  = mk(1, 230, 300, 2'b01, 16'hFFBA, 0, 1, 1, 0, "w16_sub");
        vecs[6]  = mk(1, 230, 300, 2'b10, 16'd36,  0, 0, 0, 0, "w16_and");
        vecs[7]  = mk(1, 230, 300, 2'b11, 16'd494, 0, 0, 0, 0, "w16_or");
        vecs[8]  = mk(0, 16'h7F, 16'h01, 2'b00, 16'h0080, 0, 1, 0, 1, "w8_ovf_add");
        vecs[9]  = mk(0, 16'hFF, 16'h01, 2'b00, 16'h0000, 1, 0, 1, 0, "w8_carry_add");
        vecs[10] = mk(0, 16'h80, 16'h01, 2'b01, 16'h007F, 0, 0, 0, 1, "w8_ovf_sub");
        vecs[11] = mk(0, 16'hF0, 16'h0F, 2'b11, 16'h00FF, 0, 1, 0, 0, "w8_or_all");
        vecs[12] = mk(1, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 0, 1, 0, 1, "w16_ovf_add");
        vecs[13] = mk(1, 16'h0000, 16'h0001, 2'b01, 16'hFFFF, 0, 1, 1, 0, "w16_borrow");
        vecs[14] = mk(0, 16'h80, 16'h80, 2'b00, 16'h0000, 1, 0, 1, 1, "w8_negovf");
        vecs[15] = mk(0, 16'hAA, 16'h55, 2'b10, 16'h0000, 1, 0, 0, 0, "w8_and_zero");

        #12;
        chk("reset8", {r8, 3'b0, ov8, z8, n8, c8, v8}, {8'h00, 8'b0000_1000});
        chk("reset16", {11'h0, ov16, z16, n16, c16, v16}, 16'h0008);
        chk("reset16.result", r16, 16'h0);
        @(negedge clk);
        reset = 0;

        foreach (vecs[i]) run_op(vecs[i]);

        // hold: one valid add then idle cycles with changing inputs
        run_op(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv8 = 0; iv16 = 0; a8 = 8'(i * 37 + 5); b8 = 8'(i + 90); op = 2'(i + 1);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d.valid", i), {15'h0, ov8}, 16'h0);
            chk($sformatf("hold%0d.result", i), {8'h0, r8}, 16'd30);
        end

        // asynchronous reset between edges
        run_op(mk(0, 50, 3, 2'b00, 16'd53, 0, 0, 0, 0, "pre_reset"));
        #2 reset = 1;
        #1;
        chk("async_reset8", {r8, 5'b0, ov8, z8, 1'b0}, {8'h00, 8'b0000_0010});
        chk("async_reset16", {15'h0, ov16}, 16'h0);
        @(negedge clk);
        reset = 0;
        run_op(mk(0, 16'hFE, 16'h03, 2'b01, 16'h00FB, 0, 1, 0, 0, "post_reset"));

        // back-to-back alternating add/sub with random operands
        for (int i = 0; i < 8; i++)
            run_op(model8($urandom_range(0, 255), $urandom_range(0, 255), 2'(i % 2)));

        @(negedge clk);
        iv8 = 0; iv16 = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
